riscv_exec_ctrl: RTL and testbench

Combinational execute/control core of the single-cycle RV32I simulator datapath. It produces the sequential PC (PC+4), decodes the current instruction into datapath select and enable signals, resolves branches from the register operands, and evaluates the ALU result. It sits between the instruction memory/register file and the operand, write-back and next-PC multiplexers. One registered status bit records illegal instructions.

---
 rtl/riscv_pkg.sv | 92 +++++++++
 rtl/riscv_alu.sv | 45 ++++
 rtl/riscv_exec_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_riscv_exec_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared encodings for the RV32I execute/control slice: opcodes,
//           the ECALL/EBREAK words, ALU function codes and the select
//           encodings driven onto the external datapath multiplexers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_COPY1 = 5'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JAL    = 3'd2,
    PC_JALR   = 3'd3,
    PC_EXC    = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMMI = 2'd1,
    OP2_IMMS = 2'd2,
    OP2_PC   = 2'd3
  } op2_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_CSR = 2'd1,
    WB_PC4 = 2'd2,
    WB_MEM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10,
    MEM_WORD = 2'b11
  } mem_val_e;

  // Non-subtracting/non-arithmetic-shift ALU op for a given funct3; the
  // funct7[5] alternates (SUB/SRA) are resolved by the caller.
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_alu.sv
// ============================================================================
// Module  : riscv_alu
// Purpose : RV32I integer ALU, purely combinational.
// Ports   : op1_i, op2_i  - operands
//           alufun_i      - function code (riscv_pkg::alu_op_e)
//           alu_out_o     - result; unused codes yield 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      alufun_i,
  output logic [XLEN-1:0] alu_out_o
);

  logic [4:0] shamt;
  assign shamt = op2_i[4:0];

  always_comb begin
    alu_out_o = '0;
    case (alufun_i)
      ALU_ADD:   alu_out_o = op1_i + op2_i;
      ALU_SUB:   alu_out_o = op1_i - op2_i;
      ALU_SLL:   alu_out_o = op1_i << shamt;
      ALU_SLT:   alu_out_o = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
      ALU_SLTU:  alu_out_o = {{(XLEN-1){1'b0}}, op1_i < op2_i};
      ALU_XOR:   alu_out_o = op1_i ^ op2_i;
      ALU_SRL:   alu_out_o = op1_i >> shamt;
      ALU_SRA:   alu_out_o = $unsigned($signed(op1_i) >>> shamt);
      ALU_OR:    alu_out_o = op1_i | op2_i;
      ALU_AND:   alu_out_o = op1_i & op2_i;
      ALU_COPY1: alu_out_o = op1_i;
      default:   alu_out_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_exec_ctrl.sv
// ============================================================================
// Module  : riscv_exec_ctrl
// Purpose : Execute/control core of the single-cycle RV32I datapath.
//           Produces PC+4, decodes the instruction into mux selects and
//           enables, resolves branches from rs1/rs2, evaluates the ALU on the
//           externally muxed operands, and keeps a sticky illegal flag.
// Ports   : clock, reset          - clock, sync active-high reset
//           instruction, current_pc, rs1, rs2, op1, op2 - datapath inputs
//           next_pc, alu_out      - PC+4 and ALU result
//           pc_sel, alufun, op1sel, op2sel, wb_sel     - mux selects
//           rf_wen, mem_rw, mem_val, mem_unsigned      - enables
//           illegal, illegal_seen - current / sticky undecodable flag
//           XLEN must be 32.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_exec_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] current_pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] alu_out,
  output logic [2:0]      pc_sel,
  output logic [4:0]      alufun,
  output logic            op1sel,
  output logic [1:0]      op2sel,
  output logic [1:0]      wb_sel,
  output logic            rf_wen,
  output logic            mem_rw,
  output logic [1:0]      mem_val,
  output logic            mem_unsigned,
  output logic            illegal,
  output logic            illegal_seen
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       br_taken;
  logic       undecodable;
  logic       illegal_seen_q;
  logic       illegal_seen_d;

  assign opcode = instruction[6:0];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];

  assign next_pc = current_pc + XLEN'(4);

  // Branch condition; encodings 010/011 are rejected in decode.
  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (rs1 == rs2);
      3'b001:  br_taken = (rs1 != rs2);
      3'b100:  br_taken = ($signed(rs1) <  $signed(rs2));
      3'b101:  br_taken = ($signed(rs1) >= $signed(rs2));
      3'b110:  br_taken = (rs1 <  rs2);
      3'b111:  br_taken = (rs1 >= rs2);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_sel       = PC_PLUS4;
    alufun       = ALU_ADD;
    op1sel       = 1'b0;
    op2sel       = OP2_RS2;
    wb_sel       = WB_ALU;
    rf_wen       = 1'b0;
    mem_rw       = 1'b0;
    mem_val      = MEM_NONE;
    mem_unsigned = 1'b0;
    undecodable  = 1'b0;

    case (opcode)
      OPC_OP: begin
        rf_wen = 1'b1;
        if (f7 == F7_BASE) begin
          alufun = alu_from_f3(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          alufun = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          alufun = ALU_SRA;
        end else begin
          undecodable = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        rf_wen = 1'b1;
        op2sel = OP2_IMMI;
        // Only the shift-immediates constrain the upper immediate bits.
        if (f3 == 3'b001) begin
          if (f7 == F7_BASE) alufun = ALU_SLL;
          else               undecodable = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7 == F7_BASE)     alufun = ALU_SRL;
          else if (f7 == F7_ALT) alufun = ALU_SRA;
          else                   undecodable = 1'b1;
        end else begin
          alufun = alu_from_f3(f3);
        end
      end

      OPC_LUI: begin
        rf_wen = 1'b1;
        op1sel = 1'b1;
        alufun = ALU_COPY1;
      end

      OPC_AUIPC: begin
        rf_wen = 1'b1;
        op1sel = 1'b1;
        op2sel = OP2_PC;
      end

      OPC_JAL: begin
        pc_sel = PC_JAL;
        wb_sel = WB_PC4;
        rf_wen = 1'b1;
      end

      OPC_JALR: begin
        pc_sel = PC_JALR;
        op2sel = OP2_IMMI;
        wb_sel = WB_PC4;
        rf_wen = 1'b1;
        if (f3 != 3'b000) undecodable = 1'b1;
      end

      OPC_LOAD: begin
        op2sel = OP2_IMMI;
        wb_sel = WB_MEM;
        rf_wen = 1'b1;
        case (f3)
          3'b000:  mem_val = MEM_BYTE;
          3'b001:  mem_val = MEM_HALF;
          3'b010:  mem_val = MEM_WORD;
          3'b100: begin mem_val = MEM_BYTE; mem_unsigned = 1'b1; end
          3'b101: begin mem_val = MEM_HALF; mem_unsigned = 1'b1; end
          default: undecodable = 1'b1;
        endcase
      end

      OPC_STORE: begin
        op2sel = OP2_IMMS;
        mem_rw = 1'b1;
        case (f3)
          3'b000:  mem_val = MEM_BYTE;
          3'b001:  mem_val = MEM_HALF;
          3'b010:  mem_val = MEM_WORD;
          default: undecodable = 1'b1;
        endcase
      end

      OPC_BRANCH: begin
        if (f3 == 3'b010 || f3 == 3'b011) undecodable = 1'b1;
        else if (br_taken)                pc_sel = PC_BRANCH;
      end

      OPC_SYSTEM: begin
        if (instruction != ECALL_WORD && instruction != EBREAK_WORD) begin
          if (f3 == 3'b000 || f3 == 3'b100) begin
            undecodable = 1'b1;
          end else begin
            wb_sel = WB_CSR;
            rf_wen = 1'b1;
          end
        end
      end

      default: undecodable = 1'b1;
    endcase

    // Unknown bits are treated as illegal; synthesis sees $isunknown as 0.
    if (undecodable || $isunknown(instruction)) begin
      pc_sel       = PC_EXC;
      alufun       = ALU_ADD;
      op1sel       = 1'b0;
      op2sel       = OP2_RS2;
      wb_sel       = WB_ALU;
      rf_wen       = 1'b0;
      mem_rw       = 1'b0;
      mem_val      = MEM_NONE;
      mem_unsigned = 1'b0;
    end
  end

  assign illegal = (pc_sel == PC_EXC);

  riscv_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op1_i     (op1),
    .op2_i     (op2),
    .alufun_i  (alufun),
    .alu_out_o (alu_out)
  );

  // Sticky flag: reset has priority over a simultaneous illegal instruction.
  always_comb begin
    illegal_seen_d = illegal_seen_q | illegal;
    if (reset) illegal_seen_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    illegal_seen_q <= illegal_seen_d;
  end

  assign illegal_seen = illegal_seen_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_exec_ctrl.sv
// ============================================================================
// Module  : tb_riscv_exec_ctrl
// Purpose : Self-checking bench for riscv_exec_ctrl. A mnemonic-level
//           reference model predicts every output each cycle; directed
//           literal checks pin the model to hand-computed values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_exec_ctrl;

  typedef struct packed {
    logic [31:0] next_pc;
    logic [31:0] alu_out;
    logic [2:0]  pc_sel;
    logic [4:0]  alufun;
    logic        op1sel;
    logic [1:0]  op2sel;
    logic [1:0]  wb_sel;
    logic        rf_wen;
    logic        mem_rw;
    logic [1:0]  mem_val;
    logic        mem_unsigned;
    logic        illegal;
  } out_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction, current_pc, rs1, rs2, op1, op2;
  logic [31:0] next_pc, alu_out;
  logic [2:0]  pc_sel;
  logic [4:0]  alufun;
  logic        op1sel;
  logic [1:0]  op2sel, wb_sel, mem_val;
  logic        rf_wen, mem_rw, mem_unsigned, illegal, illegal_seen;

  int n_vec = 0;
  int n_mis = 0;
  logic seen_m = 1'b0;

  always #5 clock = ~clock;

  riscv_exec_ctrl #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .current_pc(current_pc), .rs1(rs1), .rs2(rs2), .op1(op1), .op2(op2),
    .next_pc(next_pc), .alu_out(alu_out), .pc_sel(pc_sel), .alufun(alufun),
    .op1sel(op1sel), .op2sel(op2sel), .wb_sel(wb_sel), .rf_wen(rf_wen),
    .mem_rw(mem_rw), .mem_val(mem_val), .mem_unsigned(mem_unsigned),
    .illegal(illegal), .illegal_seen(illegal_seen)
  );

  // ---------------- reference model ----------------
  function automatic string mnem(input logic [31:0] i);
    casez (i)
      32'h0000_0073: return "ECALL";
      32'h0010_0073: return "EBREAK";
      32'b?????????????????????????_0110111: return "LUI";
      32'b?????????????????????????_0010111: return "AUIPC";
      32'b?????????????????????????_1101111: return "JAL";
      32'b?????????????????_000_?????_1100111: return "JALR";
      32'b?????????????????_000_?????_1100011: return "BEQ";
      32'b?????????????????_001_?????_1100011: return "BNE";
      32'b?????????????????_100_?????_1100011: return "BLT";
      32'b?????????????????_101_?????_1100011: return "BGE";
      32'b?????????????????_110_?????_1100011: return "BLTU";
      32'b?????????????????_111_?????_1100011: return "BGEU";
      32'b?????????????????_000_?????_0000011: return "LB";
      32'b?????????????????_001_?????_0000011: return "LH";
      32'b?????????????????_010_?????_0000011: return "LW";
      32'b?????????????????_100_?????_0000011: return "LBU";
      32'b?????????????????_101_?????_0000011: return "LHU";
      32'b?????????????????_000_?????_0100011: return "SB";
      32'b?????????????????_001_?????_0100011: return "SH";
      32'b?????????????????_010_?????_0100011: return "SW";
      32'b?????????????????_000_?????_0010011: return "ADDI";
      32'b?????????????????_010_?????_0010011: return "SLTI";
      32'b?????????????????_011_?????_0010011: return "SLTIU";
      32'b?????????????????_100_?????_0010011: return "XORI";
      32'b?????????????????_110_?????_0010011: return "ORI";
      32'b?????????????????_111_?????_0010011: return "ANDI";
      32'b0000000_??????????_001_?????_0010011: return "SLLI";
      32'b0000000_??????????_101_?????_0010011: return "SRLI";
      32'b0100000_??????????_101_?????_0010011: return "SRAI";
      32'b0000000_??????????_000_?????_0110011: return "ADD";
      32'b0100000_??????????_000_?????_0110011: return "SUB";
      32'b0000000_??????????_001_?????_0110011: return "SLL";
      32'b0000000_??????????_010_?????_0110011: return "SLT";
      32'b0000000_??????????_011_?????_0110011: return "SLTU";
      32'b0000000_??????????_100_?????_0110011: return "XOR";
      32'b0000000_??????????_101_?????_0110011: return "SRL";
      32'b0100000_??????????_101_?????_0110011: return "SRA";
      32'b0000000_??????????_110_?????_0110011: return "OR";
      32'b0000000_??????????_111_?????_0110011: return "AND";
      32'b?????????????????_001_?????_1110011: return "CSRRW";
      32'b?????????????????_010_?????_1110011: return "CSRRS";
      32'b?????????????????_011_?????_1110011: return "CSRRC";
      32'b?????????????????_101_?????_1110011: return "CSRRWI";
      32'b?????????????????_110_?????_1110011: return "CSRRSI";
      32'b?????????????????_111_?????_1110011: return "CSRRCI";
      default: return "ILLEGAL";
    endcase
  endfunction

  function automatic logic [4:0] code_of(input string m);
    case (m)
      "SUB": return 5'd1;
      "SLL", "SLLI": return 5'd2;
      "SLT", "SLTI": return 5'd3;
      "SLTU", "SLTIU": return 5'd4;
      "XOR", "XORI": return 5'd5;
      "SRL", "SRLI": return 5'd6;
      "SRA", "SRAI": return 5'd7;
      "OR", "ORI": return 5'd8;
      "AND", "ANDI": return 5'd9;
      "LUI": return 5'd10;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [4:0] c, input logic [31:0] a, b);
    int sh = int'(b % 32);
    case (c)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << sh;
      5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> sh;
      5'd7:  return $unsigned($signed(a) >>> sh);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic out_t model(input logic [31:0] ins, pc, a, b, o1, o2);
    out_t  e = '0;
    string m = mnem(ins);
    logic  tk = 1'b0;
    e.next_pc = pc + 32'd4;
    e.alufun  = code_of(m);
    case (m)
      "ADD", "SUB", "SLL", "SLT", "SLTU", "XOR", "SRL", "SRA", "OR", "AND":
        e.rf_wen = 1;
      "ADDI", "SLTI", "SLTIU", "XORI", "ORI", "ANDI", "SLLI", "SRLI", "SRAI":
        begin e.rf_wen = 1; e.op2sel = 2'd1; end
      "LUI":   begin e.rf_wen = 1; e.op1sel = 1; end
      "AUIPC": begin e.rf_wen = 1; e.op1sel = 1; e.op2sel = 2'd3; end
      "JAL":   begin e.pc_sel = 3'd2; e.wb_sel = 2'd2; e.rf_wen = 1; end
      "JALR":  begin e.pc_sel = 3'd3; e.op2sel = 2'd1; e.wb_sel = 2'd2; e.rf_wen = 1; end
      "LB", "LH", "LW", "LBU", "LHU": begin
        e.rf_wen = 1; e.op2sel = 2'd1; e.wb_sel = 2'd3;
        e.mem_val = (m == "LW") ? 2'b11 : (m == "LH" || m == "LHU") ? 2'b10 : 2'b01;
        e.mem_unsigned = (m == "LBU" || m == "LHU");
      end
      "SB", "SH", "SW": begin
        e.op2sel = 2'd2; e.mem_rw = 1;
        e.mem_val = (m == "SW") ? 2'b11 : (m == "SH") ? 2'b10 : 2'b01;
      end
      "BEQ", "BNE", "BLT", "BGE", "BLTU", "BGEU": begin
        case (m)
          "BEQ":   tk = (a == b);
          "BNE":   tk = (a != b);
          "BLT":   tk = ($signed(a) < $signed(b));
          "BGE":   tk = ($signed(a) >= $signed(b));
          "BLTU":  tk = (a < b);
          default: tk = (a >= b);
        endcase
        e.pc_sel = tk ? 3'd1 : 3'd0;
      end
      "CSRRW", "CSRRS", "CSRRC", "CSRRWI", "CSRRSI", "CSRRCI":
        begin e.wb_sel = 2'd1; e.rf_wen = 1; end
      "ECALL", "EBREAK": ;
      default: begin e.illegal = 1; e.pc_sel = 3'd4; end
    endcase
    e.alu_out = alu_ref(e.alufun, o1, o2);
    return e;
  endfunction

  // Sticky-flag reference: reset beats a simultaneous illegal.
  always @(posedge clock) begin
    out_t now_m;
    now_m = model(instruction, current_pc, rs1, rs2, op1, op2);
    if (reset)              seen_m <= 1'b0;
    else if (now_m.illegal) seen_m <= 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    out_t e, a;
    e = model(instruction, current_pc, rs1, rs2, op1, op2);
    a = '{next_pc, alu_out, pc_sel, alufun, op1sel, op2sel, wb_sel,
          rf_wen, mem_rw, mem_val, mem_unsigned, illegal};
    n_vec++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL outputs %s ins=%h: got %h expected %h",
               mnem(instruction), instruction, a, e);
    end
    n_vec++;
    if (illegal_seen !== seen_m) begin
      n_mis++;
      $display("FAIL illegal_seen: got %b expected %b", illegal_seen, seen_m);
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic [31:0] ins, pc, a, b, o1, o2);
    @(posedge clock); #1;
    instruction = ins; current_pc = pc; rs1 = a; rs2 = b; op1 = o1; op2 = o2;
  endtask

  task automatic settle();
    @(negedge clock); #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    reset = 1'b1;
    instruction = NOP; current_pc = 0; rs1 = 0; rs2 = 0; op1 = 0; op2 = 0;
    repeat (2) @(posedge clock);
    apply(NOP, 32'h100, 0, 0, 0, 0); reset = 1'b0;
    settle();
    lit("reset_seen", {31'd0, illegal_seen}, 32'd0);
    lit("pc4", next_pc, 32'h0000_0104);

    apply(NOP, 32'hFFFF_FFFC, 0, 0, 0, 0); settle();
    lit("pc4_wrap", next_pc, 32'h0000_0000);

    apply(32'h4031_50B3, 0, 0, 0, 32'h8000_0000, 1); settle();
    lit("sra", alu_out, 32'hC000_0000);
    apply(32'h0031_50B3, 0, 0, 0, 32'h8000_0000, 1); settle();
    lit("srl", alu_out, 32'h4000_0000);
    apply(32'h0031_20B3, 0, 0, 0, 32'h8000_0000, 1); settle();
    lit("slt", alu_out, 32'd1);
    apply(32'h0031_30B3, 0, 0, 0, 32'h8000_0000, 1); settle();
    lit("sltu", alu_out, 32'd0);
    apply(32'h4031_00B3, 0, 0, 0, 32'h8000_0000, 1); settle();
    lit("sub", alu_out, 32'h7FFF_FFFF);

    apply(32'h0020_8463, 32'h40, 5, 5, 0, 0); settle();
    lit("beq_taken", {29'd0, pc_sel}, 32'd1);
    apply(32'h0020_8463, 32'h40, 5, 6, 0, 0); settle();
    lit("beq_not", {28'd0, pc_sel, rf_wen}, 32'd0);

    apply(32'h0011_2023, 0, 0, 0, 32'h10, 32'h4); settle();
    lit("sw", {24'd0, mem_rw, mem_val, op2sel, alufun, rf_wen} ,
        {24'd0, 1'b1, 2'b11, 2'd2, 5'd0, 1'b0});
    apply(32'h0001_4083, 0, 0, 0, 32'h20, 32'h3); settle();
    lit("lbu", {27'd0, mem_val, mem_unsigned, wb_sel}, {27'd0, 2'b01, 1'b1, 2'd3});

    apply(32'h0080_00EF, 32'h200, 0, 0, 0, 0); settle();
    lit("jal", {26'd0, pc_sel, wb_sel, rf_wen}, {26'd0, 3'd2, 2'd2, 1'b1});
    apply(32'h0000_0073, 0, 0, 0, 0, 0); settle();
    lit("ecall", {27'd0, pc_sel, rf_wen, illegal}, 32'd0);

    // Model-checked coverage of remaining classes and boundaries.
    apply(32'h1234_50B7, 0, 0, 0, 32'h1234_5000, 0); settle();
    apply(32'h0000_1097, 32'h80, 0, 0, 32'h1000, 32'h80); settle();
    apply(32'h0041_0093, 0, 0, 0, 7, 4); settle();
    apply(32'h0001_00E7, 32'h300, 0, 0, 32'h1000, 8); settle();
    apply(32'h0001_1083, 0, 0, 0, 2, 2); settle();
    apply(32'h0011_0023, 0, 0, 0, 3, 1); settle();
    apply(32'h0020_9463, 0, 1, 2, 0, 0); settle();
    apply(32'h0020_C463, 0, 32'hFFFF_FFFF, 1, 0, 0); settle();
    apply(32'h0020_F463, 0, 32'hFFFF_FFFF, 1, 0, 0); settle();
    apply(32'h0020_D463, 0, 32'h8000_0000, 0, 0, 0); settle();
    apply(32'h3001_10F3, 0, 0, 0, 0, 0); settle();
    apply(32'h0010_0073, 0, 0, 0, 0, 0); settle();
    apply(32'h0031_70B3, 0, 0, 0, 32'hF0F0, 32'hFF00); settle();
    apply(32'h0031_10B3, 0, 0, 0, 1, 32'h25); settle();
    apply(32'h0231_00B3, 0, 0, 0, 1, 1); settle();
    lit("mul_illegal", {31'd0, illegal}, 32'd1);
    apply(32'h4031_1093, 0, 0, 0, 1, 1); settle();
    lit("slli_f7_illegal", {31'd0, illegal}, 32'd1);

    // Sticky flag lifecycle.
    apply(32'h0000_0013, 0, 0, 0, 0, 0); reset = 1'b1; settle();
    apply(32'h0000_0013, 0, 0, 0, 0, 0); reset = 1'b0; settle();
    lit("seen_cleared", {31'd0, illegal_seen}, 32'd0);
    apply(32'hFFFF_FFFF, 0, 0, 0, 0, 0); settle();
    lit("illegal_word", {28'd0, illegal, pc_sel}, {28'd0, 1'b1, 3'd4});
    lit("seen_before_edge", {31'd0, illegal_seen}, 32'd0);
    apply(NOP, 0, 0, 0, 0, 0); settle();
    lit("seen_set", {31'd0, illegal_seen}, 32'd1);
    apply(NOP, 4, 0, 0, 0, 0); settle();
    apply(NOP, 8, 0, 0, 0, 0); settle();
    lit("seen_sticky", {31'd0, illegal_seen}, 32'd1);
    apply(32'hFFFF_FFFF, 0, 0, 0, 0, 0); reset = 1'b1; settle();
    apply(NOP, 0, 0, 0, 0, 0); reset = 1'b0; settle();
    lit("reset_beats_illegal", {31'd0, illegal_seen}, 32'd0);
    apply(NOP, 0, 0, 0, 0, 0); settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
